multi_db_counter: RTL and testbench

MULTI_DB_COUNTER -- requirements
Module: multi_db_counter

---
 rtl/mdb_pkg.sv | 5 +
 rtl/db_channel.sv | 56 +++++
 rtl/multi_db_counter.sv | 66 ++++++
 tb/tb_multi_db_counter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdb_pkg.sv
// mdb_pkg: shared debounce FSM state type and synchroniser depth
package mdb_pkg;
   typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;
   localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/db_channel.sv
// db_channel: one button channel (synchroniser, debounce FSM, stability counter, edge detector)
// RAW_COUNT_EN adds a rising-edge pulse of the synchronised, undebounced level.
module db_channel
   import mdb_pkg::*;
#(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
`ifdef RAW_COUNT_EN
   output logic raw_rise,
`endif
   output logic db_level,
   output logic tick
);
   localparam int DB_W = $clog2(DB_CYCLES);
   localparam logic [DB_W-1:0] LOAD = DB_W'(DB_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync;
   logic [DB_W-1:0] stab, stab_n;
   logic s, db_prev;
   db_state_t state, state_n;
   assign s = sync[SYNC_STAGES-1];
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         state <= ZERO;
         stab <= '0;
         db_prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], btn};
         state <= state_n;
         stab <= stab_n;
         db_prev <= db_level;
      end
   end
   // WAIT states count down the remaining stable samples; any disagreement aborts
   always_comb begin
      state_n = state;
      stab_n = stab;
      case (state)
         ZERO:  if (s) begin state_n = WAIT1; stab_n = LOAD; end
         WAIT1: if (!s) state_n = ZERO; else if (stab == '0) state_n = ONE; else stab_n = stab - 1'b1;
         ONE:   if (!s) begin state_n = WAIT0; stab_n = LOAD; end
         WAIT0: if (s) state_n = ONE; else if (stab == '0) state_n = ZERO; else stab_n = stab - 1'b1;
         default: state_n = ZERO;
      endcase
   end
   assign db_level = (state == ONE) || (state == WAIT0);
   assign tick = db_level & ~db_prev;
`ifdef RAW_COUNT_EN
   logic raw_prev;
   always_ff @(posedge clk) raw_prev <= reset ? 1'b0 : s;
   assign raw_rise = s & ~raw_prev;
`endif
endmodule

// File: rtl/multi_db_counter.sv
// multi_db_counter: N_CH debounced buttons, each with a wrap/saturating event counter
// Defining RAW_COUNT_EN adds raw_count_out, counting undebounced synchronised rising edges.
module multi_db_counter #(
   parameter int N_CH = 4,
   parameter int CNT_W = 8,
   parameter int DB_CYCLES = 1_000_000,
   parameter int SAT_MODE = 0,
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_CH-1:0]  btn,
   input  logic             clr,
   input  logic [SEL_W-1:0] sel,
   output logic [N_CH-1:0]  db_level,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  ovf,
`ifdef RAW_COUNT_EN
   output logic [CNT_W-1:0] raw_count_out,
`endif
   output logic [CNT_W-1:0] count_out
);
   logic [CNT_W-1:0] cnt [N_CH];
   logic sel_ok;
   assign sel_ok = int'(sel) < N_CH;
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
      return (&c) ? ((SAT_MODE != 0) ? c : '0) : c + 1'b1;
   endfunction
`ifdef RAW_COUNT_EN
   logic [N_CH-1:0] raw_rise;
`endif
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      db_channel #(.DB_CYCLES(DB_CYCLES)) u_ch (
         .clk(clk),
         .reset(reset),
         .btn(btn[g]),
`ifdef RAW_COUNT_EN
         .raw_rise(raw_rise[g]),
`endif
         .db_level(db_level[g]),
         .tick(tick[g])
      );
   end
   // clr has priority over a coincident tick, so that tick is dropped
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (reset || clr) begin
            cnt[i] <= '0;
            ovf[i] <= 1'b0;
         end else if (tick[i]) begin
            cnt[i] <= bump(cnt[i]);
            if (&cnt[i]) ovf[i] <= 1'b1;
         end
      end
      count_out <= (reset || !sel_ok) ? '0 : cnt[sel];
   end
`ifdef RAW_COUNT_EN
   logic [CNT_W-1:0] raw_cnt [N_CH];
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CH; i++)
         if (reset || clr) raw_cnt[i] <= '0;
         else if (raw_rise[i]) raw_cnt[i] <= bump(raw_cnt[i]);
      raw_count_out <= (reset || !sel_ok) ? '0 : raw_cnt[sel];
   end
`endif
endmodule

// File: tb/tb_multi_db_counter.sv
// tb_multi_db_counter: directed and random checks against a run-length debounce model
module tb_multi_db_counter;
   localparam int DB = 4, MAXC = 15;
   logic clk = 1'b0;
   logic reset, clr;
   logic [3:0] btn;
   logic [1:0] sel;
   logic [3:0] db0, tk0, ov0, co0, db1, tk1, ov1, co1, co3;
   logic [2:0] db3, tk3, ov3;
   int checks = 0, failures = 0;
`ifdef RAW_COUNT_EN
   logic [3:0] rc0, rc1, rc3;
`endif
   always #5 clk = ~clk;

   multi_db_counter #(.N_CH(4), .CNT_W(4), .DB_CYCLES(DB), .SAT_MODE(0)) dut0 (
      .clk(clk), .reset(reset), .btn(btn), .clr(clr), .sel(sel),
      .db_level(db0), .tick(tk0), .ovf(ov0),
`ifdef RAW_COUNT_EN
      .raw_count_out(rc0),
`endif
      .count_out(co0));
   multi_db_counter #(.N_CH(4), .CNT_W(4), .DB_CYCLES(DB), .SAT_MODE(1)) dut1 (
      .clk(clk), .reset(reset), .btn(btn), .clr(clr), .sel(sel),
      .db_level(db1), .tick(tk1), .ovf(ov1),
`ifdef RAW_COUNT_EN
      .raw_count_out(rc1),
`endif
      .count_out(co1));
   multi_db_counter #(.N_CH(3), .CNT_W(4), .DB_CYCLES(DB), .SAT_MODE(0)) dut3 (
      .clk(clk), .reset(reset), .btn(btn[2:0]), .clr(clr), .sel(sel),
      .db_level(db3), .tick(tk3), .ovf(ov3),
`ifdef RAW_COUNT_EN
      .raw_count_out(rc3),
`endif
      .count_out(co3));

   // Model: a level flips after DB+1 consecutive synchronised samples that disagree with it
   logic [3:0] s1, s2, lvl, prv, o0, o1, rp;
   int run[4], c0[4], c1[4], r0[4], r1[4];
   int e_co0, e_co1, e_co3, e_rc0, e_rc1, e_rc3;

   function automatic int bump(input int c, input int sat);
      return (c == MAXC) ? (sat ? c : 0) : c + 1;
   endfunction

   task automatic step();
      logic [3:0] t, rr;
      @(posedge clk);
      t = lvl & ~prv;
      rr = s2 & ~rp;
      e_co0 = c0[sel]; e_co1 = c1[sel]; e_co3 = (sel < 3) ? c0[sel] : 0;
      e_rc0 = r0[sel]; e_rc1 = r1[sel]; e_rc3 = (sel < 3) ? r0[sel] : 0;
      prv = lvl;
      rp = s2;
      for (int i = 0; i < 4; i++) begin
         if (clr) begin
            c0[i] = 0; c1[i] = 0; r0[i] = 0; r1[i] = 0; o0[i] = 1'b0; o1[i] = 1'b0;
         end else begin
            if (t[i]) begin
               o0[i] = o0[i] | (c0[i] == MAXC);
               o1[i] = o1[i] | (c1[i] == MAXC);
               c0[i] = bump(c0[i], 0);
               c1[i] = bump(c1[i], 1);
            end
            if (rr[i]) begin
               r0[i] = bump(r0[i], 0);
               r1[i] = bump(r1[i], 1);
            end
         end
         if (s2[i] != lvl[i]) begin
            run[i]++;
            if (run[i] == DB + 1) begin lvl[i] = ~lvl[i]; run[i] = 0; end
         end else run[i] = 0;
      end
      s2 = s1;
      s1 = btn;
      if (reset) begin
         s1 = 0; s2 = 0; lvl = 0; prv = 0; o0 = 0; o1 = 0; rp = 0;
         for (int i = 0; i < 4; i++) begin run[i] = 0; c0[i] = 0; c1[i] = 0; r0[i] = 0; r1[i] = 0; end
         e_co0 = 0; e_co1 = 0; e_co3 = 0; e_rc0 = 0; e_rc1 = 0; e_rc3 = 0;
      end
      #1;
   endtask

   task automatic press(input int ch);
      btn[ch] = 1'b1;
      repeat (10) step();
      btn[ch] = 1'b0;
      repeat (10) step();
   endtask

   task automatic test_reset();
      reset = 1'b1; clr = 1'b0; btn = '0; sel = '0;
      step(); step();
      checks++; if ({db0, tk0, ov0, co0} !== 16'h0) begin failures++; $display("FAIL reset_sat0 got=%h want=0000", {db0, tk0, ov0, co0}); end
      checks++; if ({db1, tk1, ov1, co1} !== 16'h0) begin failures++; $display("FAIL reset_sat1 got=%h want=0000", {db1, tk1, ov1, co1}); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_clean_press();
      int rise = -1, ticks = 0;
      sel = 2'd0; btn[0] = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         step();
         if (db0[0] === 1'b1 && rise < 0) rise = e;
         if (tk0[0] === 1'b1) ticks++;
      end
      btn[0] = 1'b0;
      step();
      checks++; if (rise != 7) begin failures++; $display("FAIL clean_rise_edge got=%0d want=7", rise); end
      checks++; if (ticks != 1) begin failures++; $display("FAIL clean_tick_cycles got=%0d want=1", ticks); end
      checks++; if (co0 !== 4'd1) begin failures++; $display("FAIL clean_count got=%0d want=1", co0); end
      checks++; if ({db0, tk0, ov0, co0} !== {lvl, lvl & ~prv, o0, 4'(e_co0)}) begin failures++; $display("FAIL clean_model got=%h want=%h", {db0, tk0, ov0, co0}, {lvl, lvl & ~prv, o0, 4'(e_co0)}); end
      repeat (10) step();
   endtask

   task automatic test_bounce();
      int ticks = 0;
      sel = 2'd1;
      repeat (5) begin
         btn[1] = 1'b1;
         repeat (3) begin step(); if (tk0[1] !== 1'b0) ticks++; end
         btn[1] = 1'b0;
         step(); if (tk0[1] !== 1'b0) ticks++;
      end
      repeat (10) begin step(); if (tk0[1] !== 1'b0) ticks++; end
      checks++; if (ticks != 0) begin failures++; $display("FAIL bounce_ticks got=%0d want=0", ticks); end
      checks++; if (db0[1] !== 1'b0) begin failures++; $display("FAIL bounce_level got=%b want=0", db0[1]); end
      checks++; if ({co0, co1} !== 8'h00) begin failures++; $display("FAIL bounce_count got=%h want=00", {co0, co1}); end
   endtask

   task automatic test_overflow();
      clr = 1'b1; step(); clr = 1'b0;
      sel = 2'd2;
      repeat (17) press(2);
      checks++; if ({ov0[2], co0} !== {1'b1, 4'd1}) begin failures++; $display("FAIL ovf_wrap got=%b/%0d want=1/1", ov0[2], co0); end
      checks++; if ({ov1[2], co1} !== {1'b1, 4'd15}) begin failures++; $display("FAIL ovf_sat got=%b/%0d want=1/15", ov1[2], co1); end
      checks++; if (co3 !== 4'd1) begin failures++; $display("FAIL ovf_n3 got=%0d want=1", co3); end
      checks++; if ({ov0, co0, ov1, co1} !== {o0, 4'(e_co0), o1, 4'(e_co1)}) begin failures++; $display("FAIL ovf_model got=%h want=%h", {ov0, co0, ov1, co1}, {o0, 4'(e_co0), o1, 4'(e_co1)}); end
   endtask

   task automatic test_reset_mid_wait();
      int ticks = 0;
      sel = 2'd0; btn[0] = 1'b1;
      repeat (4) step();
      reset = 1'b1; btn[0] = 1'b0;
      step();
      reset = 1'b0;
      checks++; if ({db0, db1} !== 8'h00) begin failures++; $display("FAIL rstwait_level got=%h want=00", {db0, db1}); end
      repeat (12) begin step(); if ({tk0, tk1} !== 8'h00) ticks++; end
      checks++; if (ticks != 0) begin failures++; $display("FAIL rstwait_ticks got=%0d want=0", ticks); end
      checks++; if (db0 !== 4'h0) begin failures++; $display("FAIL rstwait_level_after got=%h want=0", db0); end
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         step();
         checks++; if ({co0, co1} !== 8'h00) begin failures++; $display("FAIL rstwait_count sel=%0d got=%h want=00", s, {co0, co1}); end
      end
   endtask

   task automatic test_collision();
      int k = 0;
      sel = 2'd3;
      repeat (5) press(3);
      checks++; if (co0 !== 4'd5) begin failures++; $display("FAIL coll_pre_count got=%0d want=5", co0); end
      btn[3] = 1'b1;
      while (k < 20 && tk0[3] !== 1'b1) begin step(); k++; end
      checks++; if (tk0[3] !== 1'b1) begin failures++; $display("FAIL coll_tick_timeout got=%b want=1", tk0[3]); end
      clr = 1'b1; step(); clr = 1'b0;
      checks++; if (db0[3] !== 1'b1) begin failures++; $display("FAIL coll_level got=%b want=1", db0[3]); end
      step();
      checks++; if ({ov0[3], co0} !== 5'h00) begin failures++; $display("FAIL coll_sat0 got=%b/%0d want=0/0", ov0[3], co0); end
      checks++; if ({ov1[3], co1} !== 5'h00) begin failures++; $display("FAIL coll_sat1 got=%b/%0d want=0/0", ov1[3], co1); end
      checks++; if ({db0, ov0, co0} !== {lvl, o0, 4'(e_co0)}) begin failures++; $display("FAIL coll_model got=%h want=%h", {db0, ov0, co0}, {lvl, o0, 4'(e_co0)}); end
      btn[3] = 1'b0;
      repeat (12) step();
   endtask

   task automatic test_random();
      int hold[4];
      for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, DB + 6);
      repeat (400) begin
         for (int i = 0; i < 4; i++) begin
            hold[i]--;
            if (hold[i] == 0) begin btn[i] = ~btn[i]; hold[i] = $urandom_range(1, DB + 6); end
         end
         clr = ($urandom_range(0, 39) == 0);
         reset = ($urandom_range(0, 199) == 0);
         sel = 2'($urandom_range(0, 3));
         step();
         checks++; if ({db0, tk0, ov0, co0} !== {lvl, lvl & ~prv, o0, 4'(e_co0)}) begin failures++; $display("FAIL rand_sat0 got=%h want=%h", {db0, tk0, ov0, co0}, {lvl, lvl & ~prv, o0, 4'(e_co0)}); end
         checks++; if ({db1, tk1, ov1, co1} !== {lvl, lvl & ~prv, o1, 4'(e_co1)}) begin failures++; $display("FAIL rand_sat1 got=%h want=%h", {db1, tk1, ov1, co1}, {lvl, lvl & ~prv, o1, 4'(e_co1)}); end
         checks++; if (co3 !== 4'(e_co3)) begin failures++; $display("FAIL rand_n3_sel got=%0d want=%0d", co3, e_co3); end
`ifdef RAW_COUNT_EN
         checks++; if ({rc0, rc1, rc3} !== {4'(e_rc0), 4'(e_rc1), 4'(e_rc3)}) begin failures++; $display("FAIL rand_raw got=%h want=%h", {rc0, rc1, rc3}, {4'(e_rc0), 4'(e_rc1), 4'(e_rc3)}); end
`endif
      end
      clr = 1'b0; reset = 1'b0;
   endtask

`ifdef RAW_COUNT_EN
   task automatic test_raw();
      btn = '0;
      repeat (12) step();
      clr = 1'b1; step(); clr = 1'b0;
      sel = 2'd0;
      repeat (3) begin btn[0] = 1'b1; step(); btn[0] = 1'b0; step(); step(); end
      btn[0] = 1'b1;
      repeat (12) step();
      checks++; if (rc0 !== 4'd4) begin failures++; $display("FAIL raw_count got=%0d want=4", rc0); end
      checks++; if (co0 !== 4'd1) begin failures++; $display("FAIL raw_db_count got=%0d want=1", co0); end
   endtask
`endif

   initial begin
      s1 = '0; s2 = '0; lvl = '0; prv = '0; o0 = '0; o1 = '0; rp = '0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_overflow();
      test_reset_mid_wait();
      test_collision();
      test_random();
`ifdef RAW_COUNT_EN
      test_raw();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
